// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// overflow/underflow pulses and a selectable standard or FWFT read port.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_LVL  = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LVL  = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_s;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full_s, empty_s, wr_acc_s, rd_acc_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  // Status decode and next-state for pointers and error pulses
  always_comb begin
    empty_s  = (wr_ptr_q == rd_ptr_q);
    full_s   = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
               (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    // Extra pointer bit makes the wrapped difference equal the occupancy 0..DEPTH
    count_s  = wr_ptr_q - rd_ptr_q;
    wr_acc_s = wr_en & ~full_s;
    rd_acc_s = rd_en & ~empty_s;
    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    overflow_d  = wr_en & full_s;
    underflow_d = rd_en & empty_s;
    rd_word_s   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  end

  // Pointer and error-pulse registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array, deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign rd_data  = rd_word_s;
      assign rd_valid = ~empty_s;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
      logic                  rd_valid_q, rd_valid_d;

      // Popped word is captured and held until the next accepted read
      always_comb begin
        rd_valid_d = rd_acc_s;
        if (rd_acc_s) begin
          rd_data_d = rd_word_s;
        end else begin
          rd_data_d = rd_data_q;
        end
      end

      // Registered read port
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

  assign full         = full_s;
  assign empty        = empty_s;
  assign count        = count_s;
  assign almost_full  = (count_s >= AF_LVL);
  assign almost_empty = (count_s <= AE_LVL);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench: a standard-read and an FWFT instance share stimulus
// and are compared against a queue-based model of the FIFO.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;

  logic [7:0] rd_data0, rd_data1;
  logic       rd_valid0, rd_valid1, full0, full1, empty0, empty1;
  logic       af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
  logic [4:0] count0, count1;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [7:0] q[$];
  logic [7:0] exp_rd_data0 = 8'h00;
  logic       exp_rd_valid0 = 1'b0;
  logic       exp_ovf = 1'b0;
  logic       exp_unf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b0)) u_std (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(unf0));

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(unf1));

  // Drive one cycle, advance the model on the edge, return 1 time unit later.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    bit was_full, was_empty;
    wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk);
    was_full  = (q.size() == 16);
    was_empty = (q.size() == 0);
    exp_ovf = w && was_full;
    exp_unf = r && was_empty;
    if (r && !was_empty) begin
      exp_rd_data0  = q.pop_front();
      exp_rd_valid0 = 1'b1;
    end else begin
      exp_rd_valid0 = 1'b0;
    end
    if (w && !was_full) q.push_back(d);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({count0, empty0, full0, ae0, af0, rd_valid0, ovf0, unf0} !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_std_status got=%b exp=%b", {count0, empty0, full0, ae0, af0, rd_valid0, ovf0, unf0}, 12'b000001010000);
    end
    total++;
    if (rd_data0 !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data0); end
    total++;
    if ({count1, empty1, rd_valid1} !== {5'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL reset_fwft_status got=%b exp=0000010", {count1, empty1, rd_valid1});
    end
    @(negedge clk); rstn = 1'b1;
    // build count=7 with a read in the last cycle so rd_valid is high when reset hits
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    total++;
    if (count0 !== 5'd7 || rd_valid0 !== 1'b1) begin
      bad++; $display("FAIL reset_pre count=%0d rd_valid=%b exp 7/1", count0, rd_valid0);
    end
    #2; rstn = 1'b0; #1;
    q.delete(); exp_rd_data0 = 8'h00; exp_rd_valid0 = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    total++;
    if ({empty0, count0, ae0, rd_valid0, empty1, count1, rd_valid1} !== {1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0}) begin
      bad++; $display("FAIL reset_mid got=%b exp=%b", {empty0, count0, ae0, rd_valid0, empty1, count1, rd_valid1}, 15'b100000101000000);
    end
    @(negedge clk); rstn = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    total++;
    if (unf0 !== 1'b1 || unf1 !== 1'b1 || rd_valid0 !== 1'b0) begin
      bad++; $display("FAIL reset_underflow unf=%b%b rd_valid=%b exp 11/0", unf0, unf1, rd_valid0);
    end
    cyc(1'b0, 8'h00, 1'b0);
    total++;
    if (unf0 !== 1'b0 || unf1 !== 1'b0) begin bad++; $display("FAIL reset_underflow_end unf=%b%b exp 00", unf0, unf1); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      total++;
      if (count0 !== 5'(i + 1) || af0 !== (i + 1 >= 14) || full0 !== (i == 15) || empty0 !== 1'b0) begin
        bad++; $display("FAIL fill i=%0d count=%0d af=%b full=%b empty=%b", i, count0, af0, full0, empty0);
      end
    end
    cyc(1'b1, 8'hAA, 1'b0);
    total++;
    if (ovf0 !== 1'b1 || ovf1 !== 1'b1 || count0 !== 5'd16 || full0 !== 1'b1) begin
      bad++; $display("FAIL overflow ovf=%b%b count=%0d full=%b exp 11/16/1", ovf0, ovf1, count0, full0);
    end
    cyc(1'b0, 8'h00, 1'b0);
    total++;
    if (ovf0 !== 1'b0 || count0 !== 5'd16) begin bad++; $display("FAIL overflow_end ovf=%b count=%0d exp 0/16", ovf0, count0); end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (rd_data1 !== 8'(i)) begin bad++; $display("FAIL fwft_head i=%0d got=%h exp=%h", i, rd_data1, 8'(i)); end
      cyc(1'b0, 8'h00, 1'b1);
      total++;
      if (rd_valid0 !== 1'b1 || rd_data0 !== 8'(i)) begin
        bad++; $display("FAIL drain_data i=%0d got=%h valid=%b exp=%h", i, rd_data0, rd_valid0, 8'(i));
      end
      total++;
      if (ae0 !== (15 - i <= 2) || empty0 !== (i == 15) || count0 !== 5'(15 - i)) begin
        bad++; $display("FAIL drain_status i=%0d ae=%b empty=%b count=%0d", i, ae0, empty0, count0);
      end
    end
    cyc(1'b0, 8'h00, 1'b1);
    total++;
    if (unf0 !== 1'b1 || rd_valid0 !== 1'b0 || rd_data0 !== 8'h0F) begin
      bad++; $display("FAIL drain_underflow unf=%b valid=%b data=%h exp 1/0/0f", unf0, rd_valid0, rd_data0);
    end
    cyc(1'b0, 8'h00, 1'b0);
    total++;
    if (unf0 !== 1'b0 || rd_data0 !== 8'h0F) begin bad++; $display("FAIL drain_hold unf=%b data=%h exp 0/0f", unf0, rd_data0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] n = 8'h00;
    for (int i = 0; i < 8; i++) begin cyc(1'b1, n, 1'b0); n++; end
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, n, 1'b1); n++;
      total++;
      if (count0 !== 5'd8 || rd_valid0 !== 1'b1 || rd_data0 !== 8'(n - 8'd9) || rd_data0 !== exp_rd_data0) begin
        bad++; $display("FAIL b2b i=%0d count=%0d data=%h exp=%h", i, count0, rd_data0, 8'(n - 8'd9));
      end
      total++;
      if (rd_data1 !== q[0] || count1 !== 5'd8) begin
        bad++; $display("FAIL b2b_fwft i=%0d data=%h exp=%h count=%0d", i, rd_data1, q[0], count1);
      end
    end
    for (int i = 0; i < 8; i++) begin cyc(1'b1, n, 1'b0); n++; end
    total++;
    if (full0 !== 1'b1) begin bad++; $display("FAIL b2b_full got=%b exp=1", full0); end
    cyc(1'b1, 8'hEE, 1'b1);
    total++;
    if (ovf0 !== 1'b1 || count0 !== 5'd15 || rd_valid0 !== 1'b1 || rd_data0 !== 8'd40) begin
      bad++; $display("FAIL full_both ovf=%b count=%0d valid=%b data=%h exp 1/15/1/28", ovf0, count0, rd_valid0, rd_data0);
    end
    while (q.size() != 0) cyc(1'b0, 8'h00, 1'b1);
    total++;
    if (exp_rd_data0 === 8'hEE || empty0 !== 1'b1) begin bad++; $display("FAIL rejected_word_seen last=%h empty=%b", exp_rd_data0, empty0); end
  endtask

  task automatic test_fwft;
    cyc(1'b1, 8'h5A, 1'b0);
    total++;
    if (rd_valid1 !== 1'b1 || rd_data1 !== 8'h5A) begin bad++; $display("FAIL fwft_first valid=%b data=%h exp 1/5a", rd_valid1, rd_data1); end
    cyc(1'b1, 8'h3C, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    total++;
    if (rd_valid1 !== 1'b1 || rd_data1 !== 8'h3C) begin bad++; $display("FAIL fwft_next valid=%b data=%h exp 1/3c", rd_valid1, rd_data1); end
    cyc(1'b0, 8'h00, 1'b1);
    total++;
    if (empty1 !== 1'b1 || rd_valid1 !== 1'b0) begin bad++; $display("FAIL fwft_empty empty=%b valid=%b exp 1/0", empty1, rd_valid1); end
  endtask

  task automatic test_random;
    int n;
    logic [11:0] got, exp;
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 100) < 52, 8'($urandom), ($urandom % 100) < 48);
      n = q.size();
      exp = {5'(n), n == 16, n == 0, n >= 14, n <= 2, exp_ovf, exp_unf, exp_rd_valid0};
      got = {count0, full0, empty0, af0, ae0, ovf0, unf0, rd_valid0};
      total++;
      if (got !== exp) begin bad++; $display("FAIL rand_std_status i=%0d got=%b exp=%b", i, got, exp); end
      total++;
      if (rd_data0 !== exp_rd_data0) begin bad++; $display("FAIL rand_std_data i=%0d got=%h exp=%h", i, rd_data0, exp_rd_data0); end
      got = {count1, full1, empty1, af1, ae1, ovf1, unf1, rd_valid1};
      exp[0] = (n != 0);
      total++;
      if (got !== exp) begin bad++; $display("FAIL rand_fwft_status i=%0d got=%b exp=%b", i, got, exp); end
      if (n != 0) begin
        total++;
        if (rd_data1 !== q[0]) begin bad++; $display("FAIL rand_fwft_data i=%0d got=%h exp=%h", i, rd_data1, q[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_fwft();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parametrised FIFO with an internal inferred memory array.
It generalises the existing dual-clock FIFO for same-domain buffering and adds:
- occupancy count
- programmable almost-full/almost-empty thresholds
- sticky-free overflow/underflow error pulses
- selectable standard or first-word-fall-through (FWFT) read mode

Parameters:
DATA_WIDTH, 8, width of each stored word.
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH.
AF_THRESH, 2**ADDR_WIDTH-2, almost_full asserted when count >= AF_THRESH (legal range 1..DEPTH).
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (legal range 0..DEPTH-1).
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
clk  input  1  single clock; all logic on rising edge.
rstn  input  1  asynchronous, active-low reset.
wr_en  input  1  write request.
wr_data  input  DATA_WIDTH  write word.
rd_en  input  1  read request (FWFT: acknowledge of the presented word).
rd_data  output  DATA_WIDTH  read word.
rd_valid  output  1  rd_data holds a valid popped word.
full  output  1  DEPTH words stored.
empty  output  1  no words stored.
almost_full  output  1  count >= AF_THRESH.
almost_empty  output  1  count <= AE_THRESH.
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  output  1  one-cycle pulse: write rejected.
underflow  output  1  one-cycle pulse: read rejected.

Behaviour:
Pointers and status
- wr_ptr and rd_ptr are ADDR_WIDTH+1 bits and wrap naturally; the low ADDR_WIDTH bits address the memory.
- empty = (wr_ptr == rd_ptr).
- full = MSBs differ and the remaining bits are equal.
- full, empty, almost_* and count are decoded from registered state with no added latency. They update the cycle after the accepted operation.

Accept rules (evaluated on state before the edge)
- wr_acc = wr_en & ~full.
- rd_acc = rd_en & ~empty.
- Both accepted in the same cycle: count unchanged, both pointers advance.
- At full with wr_en & rd_en: read accepted, write rejected, overflow pulses.
- At empty with wr_en & rd_en: write accepted, read rejected, underflow pulses. No bypass of write data to read.

Count
- count += wr_acc - rd_acc. It never exceeds DEPTH or goes below 0.

Error pulses
- overflow is registered: high for exactly one cycle after an edge with wr_en & full. Memory and pointers are untouched.
- underflow follows the same rule for rd_en & empty.

FWFT=0 (standard read)
- On rd_acc, rd_data <= mem[rd_addr], available the next cycle.
- rd_valid is high for exactly that one cycle.
- rd_data holds its last value otherwise.

FWFT=1 (first-word-fall-through)
- rd_data = mem[rd_addr], combinational from the registered pointer.
- rd_valid = ~empty.
- rd_en pops the presented word; the next word appears the cycle after the pop.
- A word written into an empty FIFO is visible on rd_data one cycle after the write edge.

Reset (async assert, sync-style release)
- Pointers 0, count 0.
- empty=1, full=0, almost_empty=1, almost_full=0.
- rd_data=0 in FWFT=0; rd_valid=0; overflow=0; underflow=0.
- Memory contents are not reset.
- Reset mid-operation discards all stored words immediately. After release, reads see an empty FIFO.

Memory
- Written on wr_acc at wr_addr.
- Write and read of different addresses in the same cycle are independent.
- Same address in the same cycle is only possible when empty, and that read is rejected.

Test Plan:
Reset, all configs: assert rstn=0 mid-burst with count=7 -> same cycle empty=1, count=0, almost_empty=1, rd_valid=0; after release, rd_en gives underflow=1 for one cycle.

Fill/overflow (ADDR_WIDTH=4, AF_THRESH=14): write 0x00..0x0F on 16 cycles -> almost_full rises after the 14th write, full after the 16th, count=16. A 17th write 0xAA -> overflow pulse, count stays 16, 0xAA never read back.

Drain/underflow (FWFT=0): from full, read 16 cycles -> rd_data 0x00..0x0F, each one cycle after rd_en with rd_valid=1. almost_empty (AE_THRESH=2) rises when count=2, empty at 0. An extra rd_en -> underflow pulse, rd_data holds 0x0F.

Simultaneous and wrap-around: hold count=8 and issue wr_en & rd_en for 40 cycles with an incrementing pattern -> count stays 8, data order preserved across several pointer wraps. At full with both asserted -> read accepted, overflow=1, count=15.

FWFT=1: write 0x5A into empty -> next cycle rd_valid=1, rd_data=0x5A with no rd_en. Write 0x3C then pulse rd_en -> next cycle rd_data=0x3C. rd_en again -> empty=1, rd_valid=0.
